// File: rtl/sump_capture_core_if.sv
// Read-stream port of the SUMP capture core: CH_W-bit data with a valid/ready handshake.
interface sump_capture_core_if #(
    parameter int CH_W = 8
);
    logic [CH_W-1:0] rd_data;
    logic            rd_valid;
    logic            rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/sump_capture_core.sv
// SUMP capture engine: divided sampling into a circular RAM, masked level trigger, windowed read-out.
// Define CAP_REVERSE_READ_EN to stream the window newest-first instead of oldest-first.
module sump_capture_core #(
    parameter int CH_W       = 8,
    parameter int DEPTH_LOG2 = 13,
    parameter int DIV_W      = 24
) (
    input  logic                CAP_CLK,
    input  logic                RST,
    input  logic [CH_W-1:0]     CAP,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [CH_W-1:0]     cfg_trig_mask,
    input  logic [CH_W-1:0]     cfg_trig_val,
    input  logic [DEPTH_LOG2:0] cfg_read_cnt,
    input  logic [DEPTH_LOG2:0] cfg_delay_cnt,
    input  logic                arm,
    input  logic                abort,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    sump_capture_core_if.master rd
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] addr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t             FULL_CNT = cnt_t'(DEPTH);
    localparam cnt_t             ONE_CNT  = cnt_t'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_WAIT, ST_POST, ST_READ} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [CH_W-1:0]  mask_q;
    logic [CH_W-1:0]  val_q;
    cnt_t             read_cnt_q;
    cnt_t             delay_q;
    cnt_t             pre_q;
    cnt_t             pre_cnt_q;
    cnt_t             post_left_q;
    cnt_t             iss_cnt_q;
    cnt_t             xfer_cnt_q;
    addr_t            wr_ptr_q;
    addr_t            rd_addr_q;
    logic             ram_vld_q;
    logic [CH_W-1:0]  ram_q;
    logic [CH_W-1:0]  fifo0_q;
    logic [CH_W-1:0]  fifo1_q;
    logic [1:0]       fifo_cnt_q;
    logic             triggered_q;
    logic             done_q;

    logic [CH_W-1:0]  mem [DEPTH];

    cnt_t             read_clamp_d;
    cnt_t             delay_clamp_d;
    logic [CH_W-1:0]  match_bits;
    logic             capturing;
    logic             strobe;
    logic             trig_hit;
    logic             go_read;
    logic             rd_valid_w;
    logic             pop;
    logic             issue;
    logic [2:0]       occ_after;
    addr_t            next_wr;
    addr_t            read_start;
    addr_t            rd_step_addr;

    always_comb begin
        read_clamp_d = cfg_read_cnt;
        if ((cfg_read_cnt == '0) || (cfg_read_cnt > FULL_CNT)) begin
            read_clamp_d = FULL_CNT;
        end
        delay_clamp_d = (cfg_delay_cnt == '0) ? ONE_CNT : cfg_delay_cnt;
        if (delay_clamp_d > read_clamp_d) begin
            delay_clamp_d = read_clamp_d;
        end
    end

    for (genvar gi = 0; gi < CH_W; gi++) begin : g_match
        assign match_bits[gi] = ~mask_q[gi] | (CAP[gi] == val_q[gi]);
    end

    assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    assign strobe    = capturing && (div_cnt_q == '0);
    assign trig_hit  = &match_bits;
    assign next_wr   = wr_ptr_q + addr_t'(1);
    assign go_read   = strobe && (((state_q == ST_WAIT) && trig_hit && (delay_q == ONE_CNT)) ||
                                  ((state_q == ST_POST) && (post_left_q == ONE_CNT)));

`ifdef CAP_REVERSE_READ_EN
    assign read_start   = next_wr - addr_t'(1);
    assign rd_step_addr = rd_addr_q - addr_t'(1);
`else
    assign read_start   = next_wr - read_cnt_q[DEPTH_LOG2-1:0];
    assign rd_step_addr = rd_addr_q + addr_t'(1);
`endif

    // Reads are issued only while the 2-entry buffer plus the RAM word in flight cannot overflow.
    assign rd_valid_w = (fifo_cnt_q != 2'd0);
    assign pop        = rd_valid_w && rd.rd_ready;
    assign occ_after  = {1'b0, fifo_cnt_q} + {2'b00, ram_vld_q} - {2'b00, pop};
    assign issue      = (state_q == ST_READ) && (iss_cnt_q != read_cnt_q) && (occ_after <= 3'd1);

    assign rd.rd_data  = fifo0_q;
    assign rd.rd_valid = rd_valid_w;
    assign busy        = (state_q != ST_IDLE);
    assign triggered   = triggered_q;
    assign done        = done_q;

    always_ff @(posedge CAP_CLK) begin
        if (strobe) begin
            mem[wr_ptr_q] <= CAP;
        end
        if (issue) begin
            ram_q <= mem[rd_addr_q];
        end
    end

    always_ff @(posedge CAP_CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            div_cnt_q   <= '0;
            mask_q      <= '0;
            val_q       <= '0;
            read_cnt_q  <= '0;
            delay_q     <= '0;
            pre_q       <= '0;
            pre_cnt_q   <= '0;
            post_left_q <= '0;
            iss_cnt_q   <= '0;
            xfer_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            ram_vld_q   <= 1'b0;
            fifo0_q     <= '0;
            fifo1_q     <= '0;
            fifo_cnt_q  <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            ram_vld_q <= issue;
            if (capturing) begin
                div_cnt_q <= strobe ? div_q : (div_cnt_q - DIV_ONE);
            end
            if (strobe) begin
                wr_ptr_q <= next_wr;
            end
            if (issue) begin
                rd_addr_q <= rd_step_addr;
                iss_cnt_q <= iss_cnt_q + ONE_CNT;
            end
            if (pop) begin
                xfer_cnt_q <= xfer_cnt_q + ONE_CNT;
            end

            unique case ({ram_vld_q, pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) fifo0_q <= ram_q;
                    else                    fifo1_q <= ram_q;
                    fifo_cnt_q <= fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    fifo0_q    <= fifo1_q;
                    fifo_cnt_q <= fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fifo0_q <= ram_q;
                    end else begin
                        fifo0_q <= fifo1_q;
                        fifo1_q <= ram_q;
                    end
                end
                default: ;
            endcase

            unique case (state_q)
                ST_IDLE: begin
                    if (arm && !abort) begin
                        div_q       <= cfg_div;
                        mask_q      <= cfg_trig_mask;
                        val_q       <= cfg_trig_val;
                        read_cnt_q  <= read_clamp_d;
                        delay_q     <= delay_clamp_d;
                        pre_q       <= read_clamp_d - delay_clamp_d;
                        pre_cnt_q   <= '0;
                        wr_ptr_q    <= '0;
                        div_cnt_q   <= '0;
                        triggered_q <= 1'b0;
                        state_q     <= (read_clamp_d == delay_clamp_d) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (strobe) begin
                        pre_cnt_q <= pre_cnt_q + ONE_CNT;
                        if ((pre_cnt_q + ONE_CNT) == pre_q) state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (strobe && trig_hit) begin
                        triggered_q <= 1'b1;
                        post_left_q <= delay_q - ONE_CNT;
                        if (!go_read) state_q <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (strobe) post_left_q <= post_left_q - ONE_CNT;
                end
                ST_READ: begin
                    if (pop && ((xfer_cnt_q + ONE_CNT) == read_cnt_q)) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        triggered_q <= 1'b0;
                        fifo_cnt_q  <= '0;
                        ram_vld_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // The last stored sample is written this cycle, so the window ends at next_wr.
            if (go_read) begin
                state_q    <= ST_READ;
                rd_addr_q  <= read_start;
                iss_cnt_q  <= '0;
                xfer_cnt_q <= '0;
            end

            if (abort && (state_q != ST_IDLE)) begin
                state_q     <= ST_IDLE;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
                fifo_cnt_q  <= '0;
                ram_vld_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sump_capture_core.sv
// Bench for sump_capture_core (DEPTH_LOG2=4): directed table, abort/reset sequences, random runs vs a window model.
module tb_sump_capture_core;
    localparam int CH_W  = 8;
    localparam int DL    = 4;
    localparam int DIV_W = 24;
    localparam int DEPTH = 16;
    localparam int MAXK  = 400;
`ifdef CAP_REVERSE_READ_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic              CAP_CLK = 1'b0;
    logic              RST;
    logic [CH_W-1:0]   CAP;
    logic [DIV_W-1:0]  cfg_div;
    logic [CH_W-1:0]   cfg_trig_mask;
    logic [CH_W-1:0]   cfg_trig_val;
    logic [DL:0]       cfg_read_cnt;
    logic [DL:0]       cfg_delay_cnt;
    logic              arm;
    logic              abort;
    logic              busy;
    logic              triggered;
    logic              done;

    sump_capture_core_if #(.CH_W(CH_W)) rd_if ();

    sump_capture_core #(.CH_W(CH_W), .DEPTH_LOG2(DL), .DIV_W(DIV_W)) dut (
        .CAP_CLK      (CAP_CLK),
        .RST          (RST),
        .CAP          (CAP),
        .cfg_div      (cfg_div),
        .cfg_trig_mask(cfg_trig_mask),
        .cfg_trig_val (cfg_trig_val),
        .cfg_read_cnt (cfg_read_cnt),
        .cfg_delay_cnt(cfg_delay_cnt),
        .arm          (arm),
        .abort        (abort),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .rd           (rd_if)
    );

    always #5 CAP_CLK = ~CAP_CLK;

    typedef struct {
        int div; int mask; int val; int rcnt; int dcnt; int pat; int rdy; int abort_k;
        int exp_len; int exp_first; int exp_last; int exp_done;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] cap_tab [MAXK];
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         kt_m, kl_m;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Cycle k=0 is the arm cycle; CAP during cycle k is cap_tab[k].
    task automatic fill_cap(input int pat);
        for (int k = 0; k < MAXK; k++) begin
            case (pat)
                0: cap_tab[k] = 8'(k - 1);
                1: begin cap_tab[k] = 8'(k - 1); if (k < 20) cap_tab[k][0] = 1'b0; end
                2: cap_tab[k] = 8'(k - 1) & 8'h7F;
                default: cap_tab[k] = 8'($urandom);
            endcase
        end
    endtask

    // Sample n is taken at cycle 1+n*(div+1); the window is the read_cnt samples ending delay_cnt after the trigger.
    task automatic model(input vec_t v);
        int rc, dc, pre, t, step;
        rc = v.rcnt; if (rc == 0 || rc > DEPTH) rc = DEPTH;
        dc = (v.dcnt == 0) ? 1 : v.dcnt; if (dc > rc) dc = rc;
        pre = rc - dc; step = v.div + 1; t = -1;
        for (int n = pre; 1 + n * step < MAXK; n++) begin
            if (((cap_tab[1 + n * step] ^ 8'(v.val)) & 8'(v.mask)) == 8'h00) begin t = n; break; end
        end
        if (t >= 0 && 1 + (t + dc - 1) * step >= MAXK) t = -1;
        exp_q.delete(); kt_m = -1; kl_m = -1;
        if (t >= 0) begin
            kt_m = 1 + t * step;
            kl_m = 1 + (t + dc - 1) * step;
            for (int i = 0; i < rc; i++) begin
                if (REV) exp_q.push_front(cap_tab[1 + (t + dc - rc + i) * step]);
                else     exp_q.push_back(cap_tab[1 + (t + dc - rc + i) * step]);
            end
        end
    endtask

    function automatic logic rdy_fn(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 3) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_case(input string nm, input vec_t v);
        int first_valid_k, trig_k, done_k, last_xfer_k, ndone, end_k;
        bit stall_prev, finished;
        logic [7:0] stall_data;
        model(v);
        rx_q.delete();
        first_valid_k = -1; trig_k = -1; done_k = -1; last_xfer_k = -1;
        ndone = 0; end_k = -1; stall_prev = 0; finished = 0; stall_data = '0;
        @(negedge CAP_CLK);
        cfg_div = 24'(v.div); cfg_trig_mask = 8'(v.mask); cfg_trig_val = 8'(v.val);
        cfg_read_cnt = 5'(v.rcnt); cfg_delay_cnt = 5'(v.dcnt);
        arm = 1'b1; abort = 1'b0; CAP = cap_tab[0]; rd_if.rd_ready = 1'b0;
        for (int k = 1; k < MAXK; k++) begin
            @(negedge CAP_CLK);
            arm = 1'b0;
            abort = (v.abort_k > 0) && (k == v.abort_k);
            CAP = cap_tab[k];
            rd_if.rd_ready = rdy_fn(v.rdy, k);
            if (stall_prev && !(v.abort_k > 0 && k == v.abort_k + 1)) begin
                chk({nm, ".stall_valid"}, 32'(rd_if.rd_valid), 1);
                chk({nm, ".stall_data"}, 32'(rd_if.rd_data), 32'(stall_data));
            end
            if (rd_if.rd_valid && first_valid_k < 0) first_valid_k = k;
            if (triggered && trig_k < 0) trig_k = k;
            if (v.abort_k > 0 && k == v.abort_k) chk({nm, ".busy_at_abort"}, 32'(busy), 1);
            if (v.abort_k > 0 && k == v.abort_k + 1) begin
                chk({nm, ".abort_busy"}, 32'(busy), 0);
                chk({nm, ".abort_valid"}, 32'(rd_if.rd_valid), 0);
                chk({nm, ".abort_trig"}, 32'(triggered), 0);
                end_k = k + 4;
            end
            if (done) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    chk({nm, ".done_busy"}, 32'(busy), 0);
                    chk({nm, ".done_trig"}, 32'(triggered), 0);
                    chk({nm, ".done_valid"}, 32'(rd_if.rd_valid), 0);
                    end_k = k + 3;
                end
            end
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                rx_q.push_back(rd_if.rd_data);
                last_xfer_k = k;
            end
            stall_prev = rd_if.rd_valid && !rd_if.rd_ready;
            stall_data = rd_if.rd_data;
            if (k == end_k) begin finished = 1; break; end
        end
        abort = 1'b0; rd_if.rd_ready = 1'b0;
        chk({nm, ".run_complete"}, 32'(finished), 1);
        if (finished) begin
            chk({nm, ".done_pulses"}, 32'(ndone), 32'(v.exp_done));
            if (v.exp_done != 0) chk({nm, ".done_timing"}, 32'(done_k), 32'(last_xfer_k + 1));
            if (v.exp_len >= 0) begin
                chk({nm, ".len"}, 32'(rx_q.size()), 32'(v.exp_len));
                if (v.exp_len > 0 && rx_q.size() > 0) begin
                    chk({nm, ".first"}, 32'(rx_q[0]), 32'(v.exp_first));
                    chk({nm, ".last"}, 32'(rx_q[rx_q.size() - 1]), 32'(v.exp_last));
                end
            end else begin
                chk({nm, ".len"}, 32'(rx_q.size()), 32'(exp_q.size()));
            end
            for (int i = 0; i < rx_q.size(); i++) begin
                if (i < exp_q.size()) chk($sformatf("%s.data[%0d]", nm, i), 32'(rx_q[i]), 32'(exp_q[i]));
            end
            if (kt_m >= 0 && (v.abort_k == 0 || v.abort_k > kt_m + 1))
                chk({nm, ".trig_cycle"}, 32'(trig_k), 32'(kt_m + 1));
            if (kt_m < 0) chk({nm, ".no_trig"}, 32'(trig_k), 32'(-1));
            if (kl_m >= 0 && (v.abort_k == 0 || v.abort_k > kl_m + 3))
                chk({nm, ".first_valid_cycle"}, 32'(first_valid_k), 32'(kl_m + 3));
        end
        $display("run %s: %0d words received, %0d expected, done pulses %0d", nm, rx_q.size(), exp_q.size(), ndone);
    endtask

    task automatic rst_mid_run();
        int nd;
        fill_cap(0);
        @(negedge CAP_CLK);
        cfg_div = '0; cfg_trig_mask = '0; cfg_trig_val = '0; cfg_read_cnt = 5'd16; cfg_delay_cnt = 5'd16;
        arm = 1'b1; CAP = cap_tab[0];
        for (int k = 1; k <= 24; k++) begin
            @(negedge CAP_CLK);
            arm = 1'b0; CAP = cap_tab[k]; rd_if.rd_ready = 1'b1;
        end
        chk("rst_mid.busy_before", 32'(busy), 1);
        RST = 1'b1;
        @(negedge CAP_CLK);
        RST = 1'b0; rd_if.rd_ready = 1'b0;
        chk("rst_mid.busy", 32'(busy), 0);
        chk("rst_mid.trig", 32'(triggered), 0);
        chk("rst_mid.valid", 32'(rd_if.rd_valid), 0);
        nd = 0;
        repeat (5) begin
            @(negedge CAP_CLK);
            if (done) nd++;
        end
        chk("rst_mid.no_done", 32'(nd), 0);
        $display("run rst_mid: reset applied during read-out");
    endtask

    initial begin
        vec_t v;
        // div mask val rcnt dcnt pat rdy abort_k | exp_len first last done
        tbl[0] = '{0, 0, 0, 16, 16, 0, 0, 0, 16, REV ? 15 : 0, REV ? 0 : 15, 1};
        tbl[1] = '{0, 1, 1, 8, 3, 1, 0, 0, 8, REV ? 21 : 14, REV ? 14 : 21, 1};
        tbl[2] = '{3, 0, 0, 4, 4, 0, 0, 0, 4, REV ? 12 : 0, REV ? 0 : 12, 1};
        tbl[3] = '{0, 0, 0, 16, 16, 0, 1, 0, 16, REV ? 15 : 0, REV ? 0 : 15, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 16, REV ? 15 : 0, REV ? 0 : 15, 1};
        tbl[5] = '{0, 8'h80, 8'h80, 8, 4, 2, 0, 30, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 16, 16, 0, 0, 0, 16, REV ? 15 : 0, REV ? 0 : 15, 1};
        tbl[7] = '{0, 0, 0, 16, 16, 0, 0, 22, 4, REV ? 15 : 0, REV ? 12 : 3, 0};
        tbl[8] = '{0, 0, 0, 16, 16, 0, 2, 0, 16, REV ? 15 : 0, REV ? 0 : 15, 1};

        RST = 1'b1; arm = 1'b0; abort = 1'b0; CAP = '0; cfg_div = '0;
        cfg_trig_mask = '0; cfg_trig_val = '0; cfg_read_cnt = '0; cfg_delay_cnt = '0;
        rd_if.rd_ready = 1'b0;
        repeat (3) @(negedge CAP_CLK);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.triggered", 32'(triggered), 0);
        chk("reset.done", 32'(done), 0);
        chk("reset.rd_valid", 32'(rd_if.rd_valid), 0);
        chk("reset.rd_data", 32'(rd_if.rd_data), 0);
        RST = 1'b0;
        @(negedge CAP_CLK);

        for (int i = 0; i < 9; i++) begin
            fill_cap(tbl[i].pat);
            run_case($sformatf("tbl%0d", i), tbl[i]);
        end

        rst_mid_run();
        fill_cap(0);
        run_case("after_rst", tbl[0]);

        for (int r = 0; r < 25; r++) begin
            fill_cap(3);
            v.div = $urandom_range(0, 3);
            v.mask = (1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7));
            v.val = $urandom_range(0, 255);
            v.rcnt = $urandom_range(0, 20);
            v.dcnt = $urandom_range(0, 20);
            v.pat = 3; v.rdy = $urandom_range(0, 2); v.abort_k = 0;
            v.exp_len = -1; v.exp_first = 0; v.exp_last = 0; v.exp_done = 1;
            model(v);
            if (kl_m < 0 || kl_m > MAXK - 80) v.mask = 0;
            run_case($sformatf("rnd%0d", r), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
